// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-N counter family: digit width helper and
// direction encoding.
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int digit_width(input int modulus);
        return $clog2(modulus);
    endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One modulo-MODULUS digit with synchronous step/load and async active-low clear.
// Loaded values at or above MODULUS are clamped so q_digit never leaves range.
module mod_n_digit
    import counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int DW      = digit_width(MODULUS)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          step,
    input  logic          up_dn,
    input  logic          load,
    input  logic [DW-1:0] d_digit,
    output logic [DW-1:0] q_digit,
    output logic          at_max,
    output logic          at_min
);

    localparam logic [DW-1:0] MAX_VAL = DW'(MODULUS - 1);

    logic [DW-1:0] d_clamped;

    assign at_max    = (q_digit == MAX_VAL);
    assign at_min    = (q_digit == '0);
    assign d_clamped = (d_digit > MAX_VAL) ? MAX_VAL : d_digit;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q_digit <= '0;
        end else if (load) begin
            q_digit <= d_clamped;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                q_digit <= at_max ? '0 : q_digit + DW'(1);
            end else begin
                q_digit <= at_min ? MAX_VAL : q_digit - DW'(1);
            end
        end
    end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Synchronous multi-digit modulo-N up/down counter with load, enable and a
// combinational terminal count for chaining.
module mod_n_updown_counter
    import counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int DIGITS  = 2,
    parameter int DW      = digit_width(MODULUS)
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] d,
    output logic [DIGITS*DW-1:0] q,
    output logic                 tc
);

    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;

    // Carry ripples through a local variable; the value left after the top
    // digit is exactly the terminal count.
    always_comb begin
        logic carry;
        carry = en;
        step  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            step[i] = carry;
            carry   = carry & ((up_dn == DIR_UP) ? at_max[i] : at_min[i]);
        end
        tc = carry;
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        mod_n_digit #(
            .MODULUS (MODULUS),
            .DW      (DW)
        ) u_digit (
            .clk     (clk),
            .clear   (clear),
            .step    (step[i]),
            .up_dn   (up_dn),
            .load    (load),
            .d_digit (d[i*DW +: DW]),
            .q_digit (q[i*DW +: DW]),
            .at_max  (at_max[i]),
            .at_min  (at_min[i])
        );
    end

endmodule
